// File: rtl/mult_seq_ctrl.sv
// Sequential shift-free multiplier controller: repeated addition through an
// external adder. The smaller operand (optionally) is used as the iteration
// count, and the larger is added into the accumulator once per RUN cycle.
//
// Handshake: start is sampled on a rising edge only while idle (busy = 0);
// done is a one-cycle pulse during which product and overflow are valid.
// Both results are held until the next accepted start clears them.
module mult_seq_ctrl #(
    parameter int WIDTH         = 16,
    parameter bit SWAP_OPERANDS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] add_in1,
    output logic [WIDTH-1:0] add_in2,
    input  logic [WIDTH-1:0] add_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             overflow,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic             overflow_q, overflow_d;
    logic             do_swap;

    // Swap only when enabled and a is the smaller operand, so fewer iterations run.
    assign do_swap = SWAP_OPERANDS && (a < b);

    // The adder sees the accumulator and multiplicand straight from their flops.
    assign add_in1   = acc_q;
    assign add_in2   = mcand_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign product   = product_q;
    assign overflow  = overflow_q;
    assign state_dbg = state_q;

    // Next-state and datapath updates; every register holds unless its state acts on it.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        count_d    = count_q;
        product_d  = product_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d    = do_swap ? b : a;
                    count_d    = do_swap ? a : b;
                    acc_d      = '0;
                    overflow_d = 1'b0;
                    product_d  = '0;
                    state_d    = ((do_swap ? a : b) == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                acc_d      = add_out;
                count_d    = count_q - WIDTH'(1);
                // A wrapped unsigned sum is smaller than either addend.
                overflow_d = overflow_q | (add_out < acc_q);
                if (count_q == WIDTH'(1)) begin
                    product_d = add_out;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            count_q    <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            count_q    <= count_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
